// File: rtl/rom_dump_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rom_dump_sequencer
//
// Purpose:
//   Reads out a whole 556PT5 (3604) / 556PT4 (3601) bipolar ROM without any
//   operator interaction. Each address 0 .. 2^ADDRESS_WIDTH-1 is driven to the
//   chip together with the read operation code. The address is held for
//   SETTLE_CYCLES clocks, the data pins are then sampled, and the resulting
//   {address, data} word is offered downstream on a valid/ready handshake.
//   The dump stops after the word at the all-ones address has been accepted.
//
// Ports:
//   i_clk           clock, single domain
//   i_reset         synchronous active-high reset
//   i_start         begin a dump (looked at only while idle)
//   i_abort         stop the dump and return to idle, dropping any pending word
//   i_data_line_in  data pins from the ROM
//   o_operation     V1..V4 control code to the ROM
//   o_address_line  address pins to the ROM
//   o_out_valid     o_out_data / o_out_address / o_out_last are valid
//   i_out_ready     downstream accepts the current word
//   o_out_data      sampled ROM word
//   o_out_address   address the word was read from
//   o_out_last      word comes from the last address
//   o_busy          dump in progress (settling or presenting a word)
//   o_done          one-cycle pulse after the last word has been transferred
// -----------------------------------------------------------------------------
module rom_dump_sequencer #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 9,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [3:0]  OP_READ       = 4'b1100,
    parameter logic [3:0]  OP_IDLE       = 4'b0000
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic [DATA_WIDTH-1:0]    i_data_line_in,
    output logic [3:0]               o_operation,
    output logic [ADDRESS_WIDTH-1:0] o_address_line,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [DATA_WIDTH-1:0]    o_out_data,
    output logic [ADDRESS_WIDTH-1:0] o_out_address,
    output logic                     o_out_last,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
    // Value of the settle counter during the final settle cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t                   r_state;
    logic [CNT_W-1:0]         r_count;
    logic [ADDRESS_WIDTH-1:0] r_address;
    logic [3:0]               r_operation;
    logic                     r_out_valid;
    logic [DATA_WIDTH-1:0]    r_out_data;
    logic [ADDRESS_WIDTH-1:0] r_out_address;
    logic                     r_out_last;
    logic                     r_busy;
    logic                     r_done;

    state_t                   w_state_next;
    logic [CNT_W-1:0]         w_count_next;
    logic [ADDRESS_WIDTH-1:0] w_address_next;
    logic [3:0]               w_operation_next;
    logic                     w_out_valid_next;
    logic [DATA_WIDTH-1:0]    w_out_data_next;
    logic [ADDRESS_WIDTH-1:0] w_out_address_next;
    logic                     w_out_last_next;
    logic                     w_done_next;

    // Next-state and next-output logic. Every output is registered, so this
    // block computes the value each register takes at the coming edge.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned, which would infer a latch.
        w_state_next       = r_state;
        w_count_next       = r_count;
        w_address_next     = r_address;
        w_operation_next   = r_operation;
        w_out_valid_next   = r_out_valid;
        w_out_data_next    = r_out_data;
        w_out_address_next = r_out_address;
        w_out_last_next    = r_out_last;
        w_done_next        = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                // start together with abort leaves the sequencer idle.
                if (i_start && !i_abort) begin
                    w_state_next     = S_SETUP;
                    w_address_next   = '0;
                    w_count_next     = '0;
                    w_operation_next = OP_READ;
                end
            end
            S_SETUP: begin
                if (r_count == CNT_LAST) begin
                    // Address has been stable for SETTLE_CYCLES clocks; the
                    // ROM output is trusted here without synchronisation.
                    w_out_data_next    = i_data_line_in;
                    w_out_address_next = r_address;
                    w_out_last_next    = (r_address == '1);
                    w_out_valid_next   = 1'b1;
                    w_state_next       = S_OUTPUT;
                end else begin
                    w_count_next = r_count + 1'b1;
                end
            end
            S_OUTPUT: begin
                if (r_out_valid && i_out_ready) begin
                    w_out_valid_next = 1'b0;
                    if (r_out_last) begin
                        // The last address ends the dump, so the address
                        // counter never wraps.
                        w_state_next     = S_DONE;
                        w_operation_next = OP_IDLE;
                        w_address_next   = '0;
                        w_done_next      = 1'b1;
                    end else begin
                        w_state_next   = S_SETUP;
                        w_address_next = r_address + 1'b1;
                        w_count_next   = '0;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Abort overrides the handshake: a word on offer is dropped even if
        // it would have been accepted at this same edge.
        if (i_abort && (r_state != S_IDLE)) begin
            w_state_next     = S_IDLE;
            w_out_valid_next = 1'b0;
            w_operation_next = OP_IDLE;
            w_address_next   = '0;
            w_count_next     = '0;
            w_done_next      = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so every register updates from the
        // values present before the edge, independent of statement order.
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_address     <= '0;
            r_operation   <= OP_IDLE;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_address <= '0;
            r_out_last    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_count       <= w_count_next;
            r_address     <= w_address_next;
            r_operation   <= w_operation_next;
            r_out_valid   <= w_out_valid_next;
            r_out_data    <= w_out_data_next;
            r_out_address <= w_out_address_next;
            r_out_last    <= w_out_last_next;
            r_busy        <= (w_state_next == S_SETUP) || (w_state_next == S_OUTPUT);
            r_done        <= w_done_next;
        end
    end

    assign o_operation    = r_operation;
    assign o_address_line = r_address;
    assign o_out_valid    = r_out_valid;
    assign o_out_data     = r_out_data;
    assign o_out_address  = r_out_address;
    assign o_out_last     = r_out_last;
    assign o_busy         = r_busy;
    assign o_done         = r_done;

endmodule

// File: tb/tb_rom_dump_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_rom_dump_sequencer
//
// Purpose:
//   Self-checking bench for rom_dump_sequencer. Two instances share one clock:
//   dut_a (3-bit address, 8-bit data, 2 settle cycles) exercises the handshake,
//   back-pressure, abort, restart and reset behaviour; dut_b (8-bit address,
//   4-bit data, 1 settle cycle) performs a full 256-word dump. Expected words
//   are queued when a dump is started and compared as the DUT transfers them.
// -----------------------------------------------------------------------------
module tb_rom_dump_sequencer;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
        logic       last;
    } word_a_t;

    typedef struct {
        logic [7:0] addr;
        logic [3:0] data;
        logic       last;
    } word_b_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut_a signals
    logic       a_reset = 1'b1;
    logic       a_start = 1'b0;
    logic       a_abort = 1'b0;
    logic       a_ready = 1'b1;
    logic [7:0] a_din;
    logic [3:0] a_op;
    logic [2:0] a_aline;
    logic       a_valid;
    logic [7:0] a_data;
    logic [2:0] a_addr;
    logic       a_last;
    logic       a_busy;
    logic       a_done;

    // dut_b signals
    logic       b_reset = 1'b1;
    logic       b_start = 1'b0;
    logic       b_abort = 1'b0;
    logic       b_ready = 1'b1;
    logic [3:0] b_din;
    logic [3:0] b_op;
    logic [7:0] b_aline;
    logic       b_valid;
    logic [3:0] b_data;
    logic [7:0] b_addr;
    logic       b_last;
    logic       b_busy;
    logic       b_done;

    // ROM models: purely combinational functions of the driven address.
    assign a_din = {5'b0, a_aline} ^ 8'hA5;
    assign b_din = b_aline[3:0] ^ b_aline[7:4] ^ 4'h9;

    rom_dump_sequencer #(
        .DATA_WIDTH   (8),
        .ADDRESS_WIDTH(3),
        .SETTLE_CYCLES(2)
    ) dut_a (
        .i_clk          (clk),
        .i_reset        (a_reset),
        .i_start        (a_start),
        .i_abort        (a_abort),
        .i_data_line_in (a_din),
        .o_operation    (a_op),
        .o_address_line (a_aline),
        .o_out_valid    (a_valid),
        .i_out_ready    (a_ready),
        .o_out_data     (a_data),
        .o_out_address  (a_addr),
        .o_out_last     (a_last),
        .o_busy         (a_busy),
        .o_done         (a_done)
    );

    rom_dump_sequencer #(
        .DATA_WIDTH   (4),
        .ADDRESS_WIDTH(8),
        .SETTLE_CYCLES(1)
    ) dut_b (
        .i_clk          (clk),
        .i_reset        (b_reset),
        .i_start        (b_start),
        .i_abort        (b_abort),
        .i_data_line_in (b_din),
        .o_operation    (b_op),
        .o_address_line (b_aline),
        .o_out_valid    (b_valid),
        .i_out_ready    (b_ready),
        .o_out_data     (b_data),
        .o_out_address  (b_addr),
        .o_out_last     (b_last),
        .o_busy         (b_busy),
        .o_done         (b_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    word_a_t q_a[$];
    word_b_t q_b[$];

    int  cyc       = 0;
    int  tick_k    = 0;
    bit  a_toggle  = 1'b0;
    int  viol_bd   = 0;
    int  a_op_viol = 0;
    int  b_op_viol = 0;
    int  b_lat_viol = 0;
    int  a_xfer    = 0;
    int  b_xfer    = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor for dut_a: scoreboard, stall stability, busy/done exclusivity.
    initial begin
        bit         stall_prev = 1'b0;
        logic [7:0] s_data     = '0;
        logic [2:0] s_addr     = '0;
        logic [2:0] s_aline    = '0;
        word_a_t    e;
        forever begin
            @(negedge clk);
            if (a_busy && a_done) viol_bd++;
            if (a_busy && a_op != 4'b1100) a_op_viol++;
            if (a_valid && stall_prev) begin
                check("a_stall_data", a_data, s_data);
                check("a_stall_addr", a_addr, s_addr);
                check("a_stall_aline", a_aline, s_aline);
            end
            if (a_valid && a_ready && !a_abort && !a_reset) begin
                a_xfer++;
                if (q_a.size() == 0) begin
                    check("a_extra_word", 1, 0);
                end else begin
                    e = q_a.pop_front();
                    check("a_word_addr", a_addr, e.addr);
                    check("a_word_data", a_data, e.data);
                    check("a_word_last", a_last, e.last);
                end
            end
            stall_prev = a_valid && !a_ready && !a_abort && !a_reset;
            s_data  = a_data;
            s_addr  = a_addr;
            s_aline = a_aline;
        end
    end

    // Monitor for dut_b: scoreboard, read code while busy, one-cycle settle.
    initial begin
        logic [7:0] h1_aline = '0;
        logic       h1_valid = 1'b0;
        logic [7:0] h2_aline = '0;
        logic [3:0] h2_op    = '0;
        logic [3:0] h1_op    = '0;
        word_b_t    e;
        forever begin
            @(negedge clk);
            if (b_busy && b_done) viol_bd++;
            if (b_busy && b_op != 4'b1100) b_op_viol++;
            if (b_valid && !h1_valid) begin
                // Previous cycle: word address already driven; the cycle
                // before that: a different address or the idle code.
                if (!(h1_aline == b_addr && (h2_aline != b_addr || h2_op == 4'b0000)))
                    b_lat_viol++;
            end
            if (b_valid && b_ready && !b_abort && !b_reset) begin
                b_xfer++;
                if (q_b.size() == 0) begin
                    check("b_extra_word", 1, 0);
                end else begin
                    e = q_b.pop_front();
                    check("b_word_addr", b_addr, e.addr);
                    check("b_word_data", b_data, e.data);
                    check("b_word_last", b_last, e.last);
                end
            end
            h2_aline = h1_aline;
            h2_op    = h1_op;
            h1_aline = b_aline;
            h1_op    = b_op;
            h1_valid = b_valid;
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        tick_k++;
        if (a_toggle) a_ready = (tick_k % 3 == 0);
    endtask

    task automatic a_push_all();
        word_a_t e;
        for (int i = 0; i < 8; i++) begin
            e.addr = 3'(i);
            e.data = 8'(i) ^ 8'hA5;
            e.last = (i == 7);
            q_a.push_back(e);
        end
    endtask

    task automatic a_start_pulse(output int t0);
        a_start = 1'b1;
        tick();
        t0 = cyc;
        a_start = 1'b0;
    endtask

    task automatic a_wait_done(input int budget, output int t1, output bit seen);
        seen = 1'b0;
        t1   = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (a_done) begin
                seen = 1'b1;
                t1   = cyc;
                break;
            end
        end
    endtask

    task automatic a_check_reset_values(input string tag);
        check({tag, "_valid"}, a_valid, 0);
        check({tag, "_op"}, a_op, 4'b0000);
        check({tag, "_aline"}, a_aline, 0);
        check({tag, "_busy"}, a_busy, 0);
        check({tag, "_done"}, a_done, 0);
        check({tag, "_data"}, a_data, 0);
        check({tag, "_addr"}, a_addr, 0);
        check({tag, "_last"}, a_last, 0);
    endtask

    initial begin
        int  t0;
        int  t1;
        bit  seen;
        bit  hit;
        int  n_done;

        // Reset both instances.
        repeat (3) tick();
        a_reset = 1'b0;
        b_reset = 1'b0;
        a_check_reset_values("rst");
        check("rst_b_op", b_op, 4'b0000);

        // 1: full dump with out_ready held high.
        a_push_all();
        a_start_pulse(t0);
        check("t1_busy_after_start", a_busy, 1);
        check("t1_op_read", a_op, 4'b1100);
        a_wait_done(200, t1, seen);
        check("t1_done_seen", seen, 1);
        check("t1_done_latency", t1 - t0, 24);
        check("t1_queue_empty", q_a.size(), 0);
        tick();
        check("t1_done_one_cycle", a_done, 0);
        check("t1_idle_op", a_op, 4'b0000);
        check("t1_idle_busy", a_busy, 0);

        // 2: back-pressure, out_ready high one cycle in three.
        a_toggle = 1'b1;
        a_xfer   = 0;
        a_push_all();
        a_start_pulse(t0);
        a_wait_done(500, t1, seen);
        check("t2_done_seen", seen, 1);
        check("t2_words", a_xfer, 8);
        check("t2_queue_empty", q_a.size(), 0);
        a_toggle = 1'b0;
        a_ready  = 1'b1;
        tick();

        // 3: abort while word 3 is on offer with out_ready high.
        a_push_all();
        a_start_pulse(t0);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (a_valid && a_addr == 3'd3) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        check("t3_reached_addr3", hit, 1);
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        check("t3_valid", a_valid, 0);
        check("t3_op", a_op, 4'b0000);
        check("t3_aline", a_aline, 0);
        check("t3_busy", a_busy, 0);
        check("t3_word3_dropped", q_a.size(), 5);
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            if (a_done) n_done++;
            tick();
        end
        check("t3_no_done", n_done, 0);
        check("t3_still_idle", a_busy, 0);
        q_a.delete();
        a_push_all();
        a_start_pulse(t0);
        a_wait_done(200, t1, seen);
        check("t3_restart_done", seen, 1);
        check("t3_restart_queue_empty", q_a.size(), 0);
        tick();

        // 4: start re-pulsed during SETUP of address 2 is ignored.
        a_push_all();
        a_start_pulse(t0);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (a_busy && !a_valid && a_aline == 3'd2) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        check("t4_reached_setup2", hit, 1);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        a_wait_done(200, t1, seen);
        check("t4_done_seen", seen, 1);
        check("t4_done_latency", t1 - t0, 24);
        check("t4_queue_empty", q_a.size(), 0);
        tick();

        // 5: reset during SETUP of address 5.
        a_push_all();
        a_start_pulse(t0);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (a_busy && !a_valid && a_aline == 3'd5) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        check("t5_reached_setup5", hit, 1);
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        a_check_reset_values("t5");
        check("t5_remaining_words", q_a.size(), 3);
        q_a.delete();
        tick();
        check("t5_stays_idle", a_busy, 0);

        // 6: dut_b full 256-word dump, one settle cycle.
        for (int i = 0; i < 256; i++) begin
            word_b_t e;
            logic [7:0] ad;
            ad     = 8'(i);
            e.addr = ad;
            e.data = ad[3:0] ^ ad[7:4] ^ 4'h9;
            e.last = (i == 255);
            q_b.push_back(e);
        end
        b_start = 1'b1;
        tick();
        t0 = cyc;
        b_start = 1'b0;
        seen = 1'b0;
        t1   = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (b_done) begin
                seen = 1'b1;
                t1   = cyc;
                break;
            end
        end
        check("t6_done_seen", seen, 1);
        check("t6_done_latency", t1 - t0, 512);
        check("t6_words", b_xfer, 256);
        check("t6_queue_empty", q_b.size(), 0);
        check("t6_op_read_while_busy", b_op_viol, 0);
        check("t6_settle_one_cycle", b_lat_viol, 0);
        tick();

        check("a_op_read_while_busy", a_op_viol, 0);
        check("busy_and_done_exclusive", viol_bd, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
